// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Operand/result handshake bundle for the sequential divider.
//   in_valid / in_ready   : operand handshake (dividend, divisor sampled on accept)
//   cancel                : abort of an operation in progress
//   out_valid / out_ready : result handshake (quotient, remainder, div_zero)
//   busy                  : divider is iterating
// Modports:
//   master : operand producer / result consumer
//   slave  : the divider itself
// -----------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DWIDTH = 4
) ();

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  dividend;
   logic [DWIDTH-1:0] divisor;
   logic              cancel;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  quotient;
   logic [DWIDTH-1:0] remainder;
   logic              div_zero;
   logic              busy;

   modport master (
      output in_valid, dividend, divisor, cancel, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, busy
   );

   modport slave (
      input  in_valid, dividend, divisor, cancel, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, busy
   );

endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring radix-2 divider, one quotient bit per clock.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous reset, active-high
//   bus : seq_divider_if.slave
//         in_valid/in_ready + dividend/divisor : operand handshake
//         cancel                               : abort while iterating
//         out_valid/out_ready + quotient/remainder/div_zero : result handshake
//         busy                                 : high while iterating
// A zero divisor skips iteration and returns quotient all-ones,
// remainder = low dividend bits, div_zero = 1.
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int unsigned WIDTH  = 14,
   parameter int unsigned DWIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   seq_divider_if.slave bus
);

   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e r_state;
   state_e w_state_next;

   logic [CNTW-1:0]   r_cnt;
   logic [WIDTH-1:0]  r_shift;   // dividend shifts out the top, quotient bits in the bottom
   logic [DWIDTH-1:0] r_prem;    // partial remainder; always < divisor so DWIDTH bits suffice
   logic [DWIDTH-1:0] r_div;
   logic [WIDTH-1:0]  r_quot;
   logic [DWIDTH-1:0] r_rem;
   logic              r_dz;

   logic              w_accept;
   logic              w_zero;
   logic              w_last;
   logic [DWIDTH:0]   w_prem_shift;
   logic [DWIDTH:0]   w_prem_sub;
   logic [DWIDTH-1:0] w_prem_next;
   logic              w_qbit;
   logic [WIDTH-1:0]  w_shift_next;
   logic              w_unused;

   assign w_accept = (r_state == StIdle) && bus.in_valid && !bus.cancel;
   assign w_zero   = (bus.divisor == '0);
   assign w_last   = (r_cnt == CNTW'(1));

   // One restoring step on the DWIDTH+1 bit shifted partial remainder
   assign w_prem_shift = {r_prem, r_shift[WIDTH-1]};
   assign w_qbit       = (w_prem_shift >= {1'b0, r_div});
   assign w_prem_sub   = w_prem_shift - {1'b0, r_div};
   assign w_prem_next  = w_qbit ? w_prem_sub[DWIDTH-1:0] : w_prem_shift[DWIDTH-1:0];
   assign w_shift_next = {r_shift[WIDTH-2:0], w_qbit};

   // The difference MSB is zero whenever it is selected
   assign w_unused = w_prem_sub[DWIDTH];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_next = w_zero ? StDone : StRun;
            end
         end
         StRun: begin
            if (bus.cancel) begin
               w_state_next = StIdle;
            end else if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      bus.in_ready  = (r_state == StIdle);
      bus.busy      = (r_state == StRun);
      bus.out_valid = (r_state == StDone);
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_prem  <= '0;
         r_div   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dz    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_div   <= bus.divisor;
                  r_shift <= bus.dividend;
                  r_prem  <= '0;
                  r_dz    <= 1'b0;
                  if (w_zero) begin
                     r_cnt  <= '0;
                     r_quot <= '1;
                     r_rem  <= bus.dividend[DWIDTH-1:0];
                     r_dz   <= 1'b1;
                  end else begin
                     r_cnt <= CNTW'(WIDTH);
                  end
               end
            end
            StRun: begin
               if (!bus.cancel) begin
                  r_prem  <= w_prem_next;
                  r_shift <= w_shift_next;
                  r_cnt   <= r_cnt - CNTW'(1);
                  // Result ports only change when an operation completes
                  if (w_last) begin
                     r_quot <= w_shift_next;
                     r_rem  <= w_prem_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = r_quot;
   assign bus.remainder = r_rem;
   assign bus.div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider (WIDTH=14, DWIDTH=4). Expected results come
// from an integer model and are queued on accept, popped when out_valid rises.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int unsigned WIDTH  = 14;
   localparam int unsigned DWIDTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_divider_if #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) bus ();

   seq_divider #(
      .WIDTH (WIDTH),
      .DWIDTH(DWIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0]  q;
      logic [DWIDTH-1:0] r;
      logic              dz;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [WIDTH-1:0]  last_q = '0;
   logic [DWIDTH-1:0] last_r = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int unsigned a, input int unsigned b);
      exp_t e;
      logic [31:0] av;
      av = a;
      if (b == 0) begin
         e.q  = '1;
         e.r  = av[DWIDTH-1:0];
         e.dz = 1'b1;
      end else begin
         e.q  = WIDTH'(a / b);
         e.r  = DWIDTH'(a % b);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation: accept, wait for result, optional backpressure, release
   task automatic send(input int unsigned a, input int unsigned b, input int unsigned hold);
      exp_t e;
      int   lat;
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.dividend  = WIDTH'(a);
      bus.divisor   = DWIDTH'(b);
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      tick();
      bus.in_valid = 1'b0;
      sb.push_back(model(a, b));
      // Operand changes after accept must not disturb the operation
      bus.dividend = ~bus.dividend;
      bus.divisor  = bus.divisor + 1'b1;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 64) begin
         if (lat == 2) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            check("quot_hidden_run", 32'(bus.quotient), 32'(last_q));
         end
         tick();
         lat++;
      end
      check("latency", 32'(lat), (b == 0) ? 32'd0 : 32'(WIDTH));
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("quotient", 32'(bus.quotient), 32'(e.q));
      check("remainder", 32'(bus.remainder), 32'(e.r));
      check("div_zero", 32'(bus.div_zero), 32'(e.dz));
      check("in_ready_done", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < int'(hold); i++) begin
         bus.in_valid = 1'b1;
         tick();
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_quotient", 32'(bus.quotient), 32'(e.q));
         check("bp_remainder", 32'(bus.remainder), 32'(e.r));
      end
      // For backpressure runs in_valid stays high across the release edge
      bus.in_valid  = (hold != 0);
      bus.out_ready = 1'b1;
      tick();
      check("release_out_valid", 32'(bus.out_valid), 32'd0);
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      check("release_not_busy", 32'(bus.busy), 32'd0);
      check("release_keep_q", 32'(bus.quotient), 32'(e.q));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      last_q = e.q;
      last_r = e.r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.cancel    = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_remainder", 32'(bus.remainder), 32'd0);
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Basic operations
      send(9999, 10, 0);
      send(12345, 7, 0);
      send(16383, 1, 0);
      send(5, 9, 0);
      send(100, 0, 0);
      send(20, 3, 0);

      // Backpressure with a same-edge in_valid at release
      send(9999, 10, 6);

      // Cancel 5 edges after accept
      bus.dividend = WIDTH'(12345);
      bus.divisor  = DWIDTH'(7);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (4) tick();
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("cancel_busy", 32'(bus.busy), 32'd0);
      check("cancel_in_ready", 32'(bus.in_ready), 32'd1);
      check("cancel_out_valid", 32'(bus.out_valid), 32'd0);
      // cancel in IDLE blocks an accept
      bus.in_valid = 1'b1;
      bus.cancel   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.cancel   = 1'b0;
      check("idle_cancel_no_accept", 32'(bus.busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      check("cancel_no_result", 32'(seen), 32'd0);
      check("cancel_keep_q", 32'(bus.quotient), 32'(last_q));
      check("cancel_keep_r", 32'(bus.remainder), 32'(last_r));
      send(50, 5, 0);

      // Asynchronous reset mid-operation
      bus.dividend = WIDTH'(9999);
      bus.divisor  = DWIDTH'(10);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (7) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_quotient", 32'(bus.quotient), 32'd0);
      check("arst_remainder", 32'(bus.remainder), 32'd0);
      check("arst_div_zero", 32'(bus.div_zero), 32'd0);
      sb.delete();
      last_q = '0;
      last_r = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      send(77, 8, 0);

      // A few random operands
      for (int i = 0; i < 4; i++) begin
         send($urandom_range(16383, 0), $urandom_range(15, 0), $urandom_range(2, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
